// File: rtl/channel_error_injector_pkg.sv
// Shared types and helpers for the channel error injector.
package chan_pkg;

  typedef enum logic [1:0] {OFF, PERIODIC, RANDOM, RAND_BURST} inj_mode_t;
  typedef enum logic {IDLE, BURST} inj_state_t;

  // Galois taps for x^16 + x^14 + x^13 + x^11 + 1 (right-shifting form).
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  // Number of set bits; callers zero-extend narrower masks to 64 bits.
  function automatic logic [7:0] popcount(input logic [63:0] v);
    logic [7:0] c;
    c = '0;
    for (int i = 0; i < 64; i++) c = c + {7'b0, v[i]};
    return c;
  endfunction

endpackage

// File: rtl/channel_error_injector_if.sv
// Symbol stream from the encoder into the injector and out to the decoder.
interface channel_error_injector_if #(
  parameter int W = 2
);
  logic         valid_i;
  logic [W-1:0] sym_i;
  logic         valid_o;
  logic [W-1:0] sym_o;
  logic [W-1:0] err_o;

  modport master (output valid_i, sym_i, input valid_o, sym_o, err_o);
  modport slave  (input valid_i, sym_i, output valid_o, sym_o, err_o);
endinterface

// File: rtl/channel_error_injector_lfsr16.sv
// 16-bit Galois LFSR; advances by one step whenever step is high.
module lfsr16
  import chan_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        step,
  input  logic [15:0] seed,
  output logic [15:0] q
);

  // Load seed on reset, otherwise shift right and fold the taps in on a 1 out.
  always_ff @(posedge clk) begin
    if (rst)       q <= seed;
    else if (step) q <= {1'b0, q[15:1]} ^ (q[0] ? LFSR_TAPS : 16'h0000);
  end

endmodule

// File: rtl/channel_error_injector.sv
// Channel model between the convolutional encoder and the Viterbi decoder:
// corrupts selected symbols with cfg_bit_mask and keeps injection statistics.
module channel_error_injector
  import chan_pkg::*;
#(
  parameter int          W         = 2,
  parameter int          PERIOD_W  = 8,
  parameter int          BURST_W   = 4,
  parameter int          CNT_W     = 32,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [1:0]           cfg_mode,
  input  logic [PERIOD_W-1:0]  cfg_period,
  input  logic [BURST_W-1:0]   cfg_burst_len,
  input  logic [7:0]           cfg_threshold,
  input  logic [W-1:0]         cfg_bit_mask,
  channel_error_injector_if.slave bus,
  output logic [CNT_W-1:0]     word_ct,
  output logic [CNT_W-1:0]     inj_word_ct,
  output logic [CNT_W-1:0]     inj_bit_ct
);

  inj_mode_t          mode;
  inj_state_t         state_q, state_d;
  logic [BURST_W-1:0] rem_q, rem_d;
  logic [BURST_W-1:0] rem_start;
  logic [PERIOD_W-1:0] phase_q;
  logic [15:0]        lfsr_q;
  logic               lfsr_hi_unused;
  logic               valid;
  logic               trig;
  logic               inject;
  logic [63:0]        mask_ext;
  logic [7:0]         mask_bits;

  assign mode           = inj_mode_t'(cfg_mode);
  assign valid          = bus.valid_i;
  assign lfsr_hi_unused = ^lfsr_q[15:8];
  // A zero burst length still corrupts the triggering word.
  assign rem_start      = (cfg_burst_len == '0) ? '0 : cfg_burst_len - BURST_W'(1);

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic [7:0] b);
    logic [CNT_W:0] s;
    s = {1'b0, a} + (CNT_W+1)'(b);
    return s[CNT_W] ? {CNT_W{1'b1}} : s[CNT_W-1:0];
  endfunction

  lfsr16 u_lfsr (
    .clk  (clk),
    .rst  (rst),
    .step (valid),
    .seed (LFSR_SEED),
    .q    (lfsr_q)
  );

  // Zero-extend the flip mask for the bit counter.
  always_comb begin
    mask_ext = '0;
    mask_ext[W-1:0] = cfg_bit_mask;
    mask_bits = popcount(mask_ext);
  end

  // Trigger decision for the current word, using the LFSR value before it steps.
  always_comb begin
    trig = 1'b0;
    case (mode)
      PERIODIC:           trig = (phase_q == '0) && (cfg_period != '0);
      RANDOM, RAND_BURST: trig = (lfsr_q[7:0] < cfg_threshold);
      default:            trig = 1'b0;
    endcase
  end

  // Burst FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
    end
  end

  // Next state and per-word corrupt decision; an OFF mode aborts a burst even
  // on an idle cycle, and retriggers are ignored while a burst is running.
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    inject  = 1'b0;
    case (state_q)
      IDLE: begin
        if (valid && trig) begin
          inject = 1'b1;
          if (mode == PERIODIC || mode == RAND_BURST) begin
            rem_d = rem_start;
            if (rem_start != '0) state_d = BURST;
          end
        end
      end
      BURST: begin
        if (mode == OFF) begin
          state_d = IDLE;
          rem_d   = '0;
        end else if (valid) begin
          inject = 1'b1;
          rem_d  = rem_q - BURST_W'(1);
          if (rem_q == BURST_W'(1)) state_d = IDLE;
        end
      end
    endcase
  end

  // Burst spacing counter, runs on every valid word including burst words.
  always_ff @(posedge clk) begin
    if (rst) phase_q <= '0;
    else if (valid) begin
      if (cfg_period == '0 || phase_q >= cfg_period - PERIOD_W'(1)) phase_q <= '0;
      else phase_q <= phase_q + PERIOD_W'(1);
    end
  end

  // Registered output stage; sym_o holds across idle cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.valid_o <= 1'b0;
      bus.sym_o   <= '0;
      bus.err_o   <= '0;
    end else begin
      bus.valid_o <= valid;
      if (valid) begin
        bus.sym_o <= bus.sym_i ^ (inject ? cfg_bit_mask : '0);
        bus.err_o <= inject ? cfg_bit_mask : '0;
      end else begin
        bus.err_o <= '0;
      end
    end
  end

  // Saturating statistics counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      word_ct     <= '0;
      inj_word_ct <= '0;
      inj_bit_ct  <= '0;
    end else if (valid) begin
      word_ct <= sat_add(word_ct, 8'd1);
      if (inject) begin
        inj_word_ct <= sat_add(inj_word_ct, 8'd1);
        inj_bit_ct  <= sat_add(inj_bit_ct, mask_bits);
      end
    end
  end

endmodule

// File: doc/channel_error_injector.md
Name: channel_error_injector

Overview:
- Parametrised channel model that sits between the convolutional encoder output and the Viterbi decoder input.
- Injects bit errors into a W-bit symbol stream under runtime-selectable modes: off, periodic burst, random (LFSR, threshold-set error rate) and random-triggered burst.
- Drives the decoder with the corrupted symbol and a matching valid, with one cycle of latency.
- Keeps injected-word and injected-bit counters so the bench can correlate decoder error statistics.

Parameters:
- W, 2: symbol width in bits (encoder output width).
- PERIOD_W, 8: width of cfg_period and of the phase counter.
- BURST_W, 4: width of cfg_burst_len and of the burst counter.
- CNT_W, 32: width of the statistics counters.
- LFSR_SEED, 16'hACE1: LFSR value loaded on reset; must be nonzero.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- cfg_mode  in  2  0=OFF, 1=PERIODIC, 2=RANDOM, 3=RAND_BURST.
- cfg_period  in  PERIOD_W  periodic burst spacing in valid words; 0 disables PERIODIC triggers.
- cfg_burst_len  in  BURST_W  corrupted words per burst; 0 is treated as 1.
- cfg_threshold  in  8  random trigger fires when lfsr[7:0] < cfg_threshold (error rate threshold/256).
- cfg_bit_mask  in  W  bits XORed into a corrupted symbol.
- valid_i  in  1  input symbol valid.
- sym_i  in  W  encoder symbol.
- valid_o  out  1  registered copy of valid_i.
- sym_o  out  W  sym_i XOR (inject ? cfg_bit_mask : 0), registered.
- err_o  out  W  applied flip mask, aligned with sym_o.
- word_ct  out  CNT_W  valid words passed.
- inj_word_ct  out  CNT_W  words corrupted.
- inj_bit_ct  out  CNT_W  total bits flipped.

Behaviour:
- Reset (rst=1 at a clk edge) clears the following:
  - valid_o, sym_o, err_o and all counters to 0.
  - phase counter to 0, FSM to IDLE, burst counter to 0.
  - lfsr to LFSR_SEED.
  - Reset mid-burst aborts the burst.
- Latency: exactly 1 cycle from valid_i/sym_i to valid_o/sym_o/err_o.
- With valid_i=0, the outputs show valid_o=0 and err_o=0. sym_o holds its last value. No state advances.
- All state below advances only on valid_i=1 cycles.
- LFSR: 16-bit Galois, polynomial x^16+x^14+x^13+x^11+1.
  - Steps once per valid word.
  - Trigger comparisons use the value before the step.
- Phase counter: counts 0..cfg_period-1 and wraps to 0.
  - If cfg_period is 0, it holds at 0.
  - The PERIODIC trigger is phase==0 && cfg_period!=0, so the first valid word after reset is a trigger.
- Trigger per valid word:
  - OFF: never.
  - PERIODIC: phase trigger.
  - RANDOM and RAND_BURST: lfsr[7:0] < cfg_threshold.
- FSM state IDLE, on a valid word:
  - No trigger: pass clean.
  - Trigger in RANDOM: corrupt this word only; stay in IDLE.
  - Trigger in PERIODIC or RAND_BURST: corrupt this word, and set rem = max(cfg_burst_len,1) - 1.
    - If rem is nonzero, go to BURST.
- FSM state BURST, on a valid word:
  - Corrupt the word and decrement rem.
  - When rem reaches 0, go to IDLE.
  - Triggers are ignored (no retrigger or extension) while in BURST.
  - The phase counter keeps running during BURST.
- cfg_mode set to OFF while in BURST: return to IDLE at the next edge. That word is not corrupted.
- Other config changes mid-burst: cfg_burst_len is sampled at burst start only. cfg_bit_mask applies per word.
- Corrupted word accounting:
  - err_o = cfg_bit_mask.
  - inj_word_ct += 1.
  - inj_bit_ct += popcount(cfg_bit_mask).
  - cfg_bit_mask=0 still counts the word but adds 0 bits.
- Counters saturate at all-ones and do not wrap.

Decomposition:
- Package chan_pkg holds:
  - typedef enum logic [1:0] inj_mode_t {OFF, PERIODIC, RANDOM, RAND_BURST};
  - typedef enum logic inj_state_t {IDLE, BURST};
  - localparam LFSR_TAPS = 16'hB400.
- Sub-module lfsr16 has ports clk, rst, step, seed and q. It is the natural split and is reused by the bench stimulus generator.
- Popcount is a function in chan_pkg.

Test Plan:
- Periodic burst: PERIODIC, period=15, burst_len=2, mask=2'b01, 30 valid words of 2'b00.
  - sym_o=01 on words 0, 1, 15 and 16, clean elsewhere.
  - inj_word_ct=4, inj_bit_ct=4, word_ct=30.
- Gapped valid: same config with valid_i low every other cycle.
  - Same corrupted word indices as above; valid_o mirrors valid_i one cycle later.
- Random extremes: RANDOM, threshold=0, 1000 words gives inj_word_ct=0. threshold=255 with mask=2'b11 gives injection on every word whose lfsr[7:0]!=255; match the lfsr16 reference model exactly.
- Abort: PERIODIC, period=10, burst_len=5, mask=2'b10, switch to OFF after the 2nd corrupted word.
  - Exactly 2 words corrupted; subsequent words clean.
- Reset mid-burst: assert rst during a burst.
  - Next cycle all outputs and counters are 0.
  - After release, the first valid word triggers again (phase 0) and lfsr restarts at 16'hACE1.
- Boundary config: burst_len=0 behaves as 1; period=0 in PERIODIC gives no injection; counters preset near all-ones saturate.
